bus_node_fifo: RTL and testbench

- Per-node endpoint on the far side of the bs_gnrtr_n_rbtr bus arbiter; one instance per driver port.
- TX side: host writes packets into a FIFO; presents them to the bus through pndng/D_pop and retires one on each bus pop.
- RX side: captures bus push/D_push, keeps only packets addressed to this node (or broadcast), and queues them for the host.
- Also counts RX packets dropped because of overflow.

---
 rtl/bus_node_fifo_if.sv | 38 +++
 rtl/bus_node_fifo.sv | 114 +++++++++++
 tb/tb_bus_node_fifo.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_node_fifo_if.sv
// Host/bus handshake bundle for one bus_node_fifo endpoint.
// slave: the node itself; master: whoever drives the host and bus side.
interface bus_node_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
);
    localparam int CW = $clog2(depth + 1);

    // TX side (host -> node -> bus)
    logic               host_wr;
    logic [pckg_sz-1:0] host_wdata;
    logic               tx_full;
    logic [CW-1:0]      tx_count;
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;

    // RX side (bus -> node -> host)
    logic               push;
    logic [pckg_sz-1:0] D_push;
    logic               host_rd;
    logic [pckg_sz-1:0] host_rdata;
    logic               rx_empty;
    logic [CW-1:0]      rx_count;
    logic [7:0]         drop_cnt;

    modport slave (
        input  host_wr, host_wdata, pop, push, D_push, host_rd,
        output tx_full, tx_count, pndng, D_pop,
               host_rdata, rx_empty, rx_count, drop_cnt
    );

    modport master (
        output host_wr, host_wdata, pop, push, D_push, host_rd,
        input  tx_full, tx_count, pndng, D_pop,
               host_rdata, rx_empty, rx_count, drop_cnt
    );
endinterface

// File: rtl/bus_node_fifo.sv
// Per-node bus endpoint: a TX FIFO feeding the arbiter (pndng/D_pop/pop)
// and an address-filtered RX FIFO fed by the arbiter (push/D_push), both
// first-word-fall-through, plus a saturating counter of RX overflow drops.
module bus_node_fifo #(
    parameter int         pckg_sz = 16,
    parameter int         depth   = 8,
    parameter logic [7:0] id      = 8'h00,
    parameter logic [7:0] bdcst   = 8'hFF
) (
    input logic           clk,
    input logic           reset,
    bus_node_fifo_if.slave bus
);
    localparam int            AW       = $clog2(depth);
    localparam int            CW       = $clog2(depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    // TX storage and control
    logic [pckg_sz-1:0] tx_mem_q [depth];
    logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic               tx_empty, tx_full, tx_do_wr, tx_do_rd;

    // RX storage and control
    logic [pckg_sz-1:0] rx_mem_q [depth];
    logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic               rx_empty, rx_full, rx_do_wr, rx_do_rd;
    logic               rx_addressed, rx_drop;
    logic [7:0]         rx_dest;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    // TX next-state: a write into a full FIFO is accepted only when the
    // head is popped in the same cycle (full implies non-empty, so the pop
    // is always valid then and the write slot is the one being vacated).
    always_comb begin
        tx_empty    = (tx_cnt_q == '0);
        tx_full     = (tx_cnt_q == FULL_CNT);
        tx_do_rd    = bus.pop && !tx_empty;
        tx_do_wr    = bus.host_wr && (!tx_full || bus.pop);
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_do_wr) tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
        if (tx_do_rd) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
        case ({tx_do_wr, tx_do_rd})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    // RX next-state: filter on destination ID, store when room exists or
    // when the host frees an entry this cycle, otherwise count the drop.
    always_comb begin
        rx_dest      = bus.D_push[pckg_sz-1 -: 8];
        rx_empty     = (rx_cnt_q == '0);
        rx_full      = (rx_cnt_q == FULL_CNT);
        rx_addressed = bus.push && ((rx_dest == id) || (rx_dest == bdcst));
        rx_do_rd     = bus.host_rd && !rx_empty;
        rx_do_wr     = rx_addressed && (!rx_full || bus.host_rd);
        rx_drop      = rx_addressed && rx_full && !bus.host_rd;
        rx_wr_ptr_d  = rx_wr_ptr_q;
        rx_rd_ptr_d  = rx_rd_ptr_q;
        rx_cnt_d     = rx_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (rx_do_wr) rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
        if (rx_do_rd) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
        case ({rx_do_wr, rx_do_rd})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
        if (rx_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Pointer, occupancy and drop-counter registers; reset empties both FIFOs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Packet storage; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge clk) begin
        if (tx_do_wr) tx_mem_q[tx_wr_ptr_q] <= bus.host_wdata;
        if (rx_do_wr) rx_mem_q[rx_wr_ptr_q] <= bus.D_push;
    end

    assign bus.pndng      = !tx_empty;
    assign bus.tx_full    = tx_full;
    assign bus.tx_count   = tx_cnt_q;
    assign bus.D_pop      = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
    assign bus.rx_empty   = rx_empty;
    assign bus.rx_count   = rx_cnt_q;
    assign bus.host_rdata = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
    assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_bus_node_fifo.sv
// Self-checking bench for bus_node_fifo (id=3, depth=8, 16-bit packets):
// directed scenarios plus random traffic against a queue-based model.
module tb_bus_node_fifo;
    localparam logic [7:0] NODE_ID = 8'h03;
    localparam logic [7:0] BCAST   = 8'hFF;
    localparam int         DEPTH   = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    int          drops;

    bus_node_fifo_if #(.pckg_sz(16), .depth(DEPTH)) bif ();

    bus_node_fifo #(
        .pckg_sz(16),
        .depth  (DEPTH),
        .id     (NODE_ID),
        .bdcst  (BCAST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("pndng",      32'(bif.pndng),      32'(txq.size() != 0));
        check("D_pop",      32'(bif.D_pop),      (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
        check("tx_full",    32'(bif.tx_full),    32'(txq.size() == DEPTH));
        check("tx_count",   32'(bif.tx_count),   32'(txq.size()));
        check("rx_empty",   32'(bif.rx_empty),   32'(rxq.size() == 0));
        check("host_rdata", 32'(bif.host_rdata), (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
        check("rx_count",   32'(bif.rx_count),   32'(rxq.size()));
        check("drop_cnt",   32'(bif.drop_cnt),   32'(drops));
    endtask

    task automatic model_clear();
        txq.delete();
        rxq.delete();
        drops = 0;
    endtask

    // Apply this cycle's inputs to the model from pre-edge occupancy.
    task automatic model_step();
        bit tx_rd, tx_wr, rx_rd, rx_wr, addr, drop;
        int ts, rs;
        logic [7:0] dest;
        ts    = txq.size();
        rs    = rxq.size();
        dest  = bif.D_push[15:8];
        tx_rd = bif.pop && (ts > 0);
        tx_wr = bif.host_wr && ((ts < DEPTH) || bif.pop);
        addr  = bif.push && ((dest == NODE_ID) || (dest == BCAST));
        rx_rd = bif.host_rd && (rs > 0);
        rx_wr = addr && ((rs < DEPTH) || bif.host_rd);
        drop  = addr && (rs == DEPTH) && !bif.host_rd;
        if (tx_rd) void'(txq.pop_front());
        if (tx_wr) txq.push_back(bif.host_wdata);
        if (rx_rd) void'(rxq.pop_front());
        if (rx_wr) rxq.push_back(bif.D_push);
        if (drop && drops < 255) drops++;
    endtask

    // One clock: model follows the edge, outputs compared 1ns later.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_clear();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        bif.host_wr    = 1'b0;
        bif.host_wdata = 16'h0;
        bif.pop        = 1'b0;
        bif.push       = 1'b0;
        bif.D_push     = 16'h0;
        bif.host_rd    = 1'b0;
    endtask

    logic [15:0] ord[3];
    logic [7:0]  rdest;

    initial begin
        ord[0] = 16'h0111;
        ord[1] = 16'h0222;
        ord[2] = 16'h0333;
        model_clear();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // TX ordering
        for (int i = 0; i < 3; i++) begin
            bif.host_wr = 1'b1; bif.host_wdata = ord[i];
            cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            check("tx_order", 32'(bif.D_pop), 32'(ord[i]));
            bif.pop = 1'b1;
            cycle();
        end
        check("tx_pndng_fall", 32'(bif.pndng), 32'h0);
        cycle(); // fourth pop on empty FIFO
        check("tx_pop_empty", 32'(bif.tx_count), 32'h0);
        idle();

        // TX full boundary
        for (int i = 0; i < DEPTH; i++) begin
            bif.host_wr = 1'b1; bif.host_wdata = 16'($urandom);
            cycle();
        end
        check("tx_full_set", 32'(bif.tx_full), 32'h1);
        bif.host_wdata = 16'hDEAD;
        cycle();
        check("tx_ovf_ignored", 32'(bif.tx_count), 32'd8);
        bif.host_wdata = 16'hBEEF; bif.pop = 1'b1;
        cycle();
        check("tx_full_wr_pop", 32'(bif.tx_count), 32'd8);
        check("tx_full_stays", 32'(bif.tx_full), 32'h1);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("tx_last_beef", 32'(bif.D_pop), 32'h0000BEEF);
            bif.pop = 1'b1;
            cycle();
        end
        idle();

        // RX filter
        bif.push = 1'b1;
        bif.D_push = 16'h03AA; cycle();
        bif.D_push = 16'h05BB; cycle();
        bif.D_push = 16'hFFCC; cycle();
        idle();
        check("rx_filter_cnt", 32'(bif.rx_count), 32'd2);
        check("rx_filter_head", 32'(bif.host_rdata), 32'h000003AA);
        check("rx_filter_drop", 32'(bif.drop_cnt), 32'h0);
        bif.host_rd = 1'b1;
        cycle();
        check("rx_filter_2nd", 32'(bif.host_rdata), 32'h0000FFCC);
        cycle();
        idle();

        // RX overflow and drop counter saturation
        for (int i = 0; i < DEPTH; i++) begin
            bif.push = 1'b1; bif.D_push = {NODE_ID, 8'(i)};
            cycle();
        end
        bif.D_push = 16'h03F0; cycle();
        bif.D_push = 16'h03F1; cycle();
        check("rx_drop2", 32'(bif.drop_cnt), 32'd2);
        check("rx_ovf_head", 32'(bif.host_rdata), 32'h00000300);
        bif.D_push = 16'hFF77; bif.host_rd = 1'b1;
        cycle();
        check("rx_full_rd_cnt", 32'(bif.rx_count), 32'd8);
        check("rx_full_rd_drop", 32'(bif.drop_cnt), 32'd2);
        bif.host_rd = 1'b0;
        for (int i = 0; i < 260; i++) begin
            bif.D_push = {BCAST, 8'(i)};
            cycle();
        end
        check("rx_drop_sat", 32'(bif.drop_cnt), 32'd255);
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("rx_last_ff77", 32'(bif.host_rdata), 32'h0000FF77);
            bif.host_rd = 1'b1;
            cycle();
        end
        idle();

        // Wrap-around: interleaved write/read pairs on both paths
        for (int i = 0; i < 20; i++) begin
            idle();
            bif.host_wr = 1'b1; bif.host_wdata = 16'($urandom);
            bif.push = 1'b1; bif.D_push = {NODE_ID, 8'($urandom)};
            cycle();
            idle();
            bif.pop = 1'b1; bif.host_rd = 1'b1;
            cycle();
        end
        idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bif.host_wr    = ($urandom_range(0, 99) < 55);
            bif.host_wdata = 16'($urandom);
            bif.pop        = ($urandom_range(0, 99) < 45);
            bif.push       = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 3))
                0:       rdest = NODE_ID;
                1:       rdest = BCAST;
                2:       rdest = 8'h05;
                default: rdest = 8'($urandom);
            endcase
            bif.D_push  = {rdest, 8'($urandom)};
            bif.host_rd = ($urandom_range(0, 99) < 40);
            cycle();
        end
        idle();

        // Reset mid-traffic with 3 TX and 2 RX entries queued
        reset = 1'b1; cycle();
        reset = 1'b0; cycle();
        for (int i = 0; i < 3; i++) begin
            bif.host_wr = 1'b1; bif.host_wdata = 16'h0A00 + 16'(i);
            bif.push = (i < 2); bif.D_push = {NODE_ID, 8'(i)};
            cycle();
        end
        idle();
        check("pre_rst_tx", 32'(bif.tx_count), 32'd3);
        check("pre_rst_rx", 32'(bif.rx_count), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_pndng", 32'(bif.pndng), 32'h0);
        check("rst_rx_empty", 32'(bif.rx_empty), 32'h1);
        check("rst_tx_count", 32'(bif.tx_count), 32'h0);
        check("rst_rx_count", 32'(bif.rx_count), 32'h0);
        check("rst_drop", 32'(bif.drop_cnt), 32'h0);
        cycle();
        reset = 1'b0;
        cycle();
        check("post_rst_D_pop", 32'(bif.D_pop), 32'h0);
        check("post_rst_rdata", 32'(bif.host_rdata), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
